// File: rtl/serial_divisibility_by_n_using_fsm.sv
//==============================================================================
// Module      : serial_divisibility_by_n_using_fsm
// Description : Bit-serial remainder tracker for a constant divisor, MSB-first
//               or LSB-first per number, with clear, valid gating and a
//               saturating bit counter.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module serial_divisibility_by_n_using_fsm #(
    parameter int DIVISOR = 5,
    parameter int REM_W   = $clog2(DIVISOR),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             lsb_first,
    input  logic             valid,
    input  logic             new_bit,
    output logic             div_by_n,
    output logic [REM_W-1:0] remainder,
    output logic [CNT_W-1:0] bit_count
);

    // Elaboration guards on the divisor range and the derived remainder width.
    if ((DIVISOR < 2) || (DIVISOR > 65535)) begin : g_bad_divisor
        $error("serial_divisibility_by_n_using_fsm: DIVISOR must be in 2..65535");
    end
    if (REM_W != $clog2(DIVISOR)) begin : g_bad_rem_w
        $error("serial_divisibility_by_n_using_fsm: REM_W must equal $clog2(DIVISOR)");
    end

    localparam logic [REM_W:0]   c_div      = (REM_W+1)'(DIVISOR);
    localparam logic [REM_W-1:0] c_rem_zero = '0;
    localparam logic [REM_W-1:0] c_wgt_one  = REM_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Any sum here is below 2*DIVISOR, so one conditional subtract reduces it.
    function automatic logic [REM_W-1:0] mod_reduce(input logic [REM_W:0] sum);
        logic [REM_W:0] diff;
        diff = sum - c_div;
        return (sum >= c_div) ? diff[REM_W-1:0] : sum[REM_W-1:0];
    endfunction

    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] r_weight;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode_lsb;
    logic             r_div;

    logic [REM_W-1:0] w_rem_base;
    logic [REM_W-1:0] w_wgt_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic             w_mode;
    logic             w_bit;
    logic [REM_W:0]   w_msb_sum;
    logic [REM_W:0]   w_lsb_sum;
    logic [REM_W:0]   w_wgt_dbl;
    logic [REM_W-1:0] w_rem_next;
    logic [REM_W-1:0] w_wgt_next;
    logic [CNT_W-1:0] w_cnt_next;

    // A clear in the same cycle as a valid bit makes that bit the first bit
    // of the new number, so the arithmetic starts from the initialised state.
    always_comb begin
        w_rem_base = clear ? c_rem_zero : r_rem;
        w_wgt_base = clear ? c_wgt_one  : r_weight;
        w_cnt_base = clear ? c_cnt_zero : r_cnt;
        w_mode     = clear ? lsb_first  : r_mode_lsb;
        w_bit      = valid & new_bit;
    end

    always_comb begin
        w_msb_sum = {w_rem_base, w_bit};
        w_lsb_sum = {1'b0, w_rem_base} + ({1'b0, w_wgt_base} & {(REM_W+1){w_bit}});
        w_wgt_dbl = {w_wgt_base, 1'b0};
        w_rem_next = w_mode ? mod_reduce(w_lsb_sum) : mod_reduce(w_msb_sum);
        w_wgt_next = w_mode ? mod_reduce(w_wgt_dbl) : w_wgt_base;
        w_cnt_next = (&w_cnt_base) ? w_cnt_base : (w_cnt_base + c_cnt_one);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem      <= c_rem_zero;
            r_weight   <= c_wgt_one;
            r_cnt      <= c_cnt_zero;
            r_mode_lsb <= 1'b0;
            r_div      <= 1'b1;
        end else begin
            if (clear) begin
                r_mode_lsb <= lsb_first;
            end
            if (valid) begin
                r_rem    <= w_rem_next;
                r_weight <= w_wgt_next;
                r_cnt    <= w_cnt_next;
                r_div    <= (w_rem_next == c_rem_zero);
            end else if (clear) begin
                r_rem    <= c_rem_zero;
                r_weight <= c_wgt_one;
                r_cnt    <= c_cnt_zero;
                r_div    <= 1'b1;
            end
        end
    end

    assign remainder = r_rem;
    assign div_by_n  = r_div;
    assign bit_count = r_cnt;

endmodule

`default_nettype wire
